calc_vector_checker: RTL and testbench

//  Hardware counterpart of the calculator's exhaustive bench: sequences all 16 input

---
 rtl/calc_vector_checker.sv | 148 ++++++++++++++
 tb/tb_calc_vector_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_vector_checker.sv
// Sweeps all 16 {a,b,c,d} vectors through a 4-in/2-out calculator and checks y/z against
// expected truth tables. Define CALC_CHK_STOP_ON_ERR_EN to end the sweep at the first mismatch.
module calc_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED_Y    = 16'h6996,
  parameter logic [15:0] EXPECTED_Z    = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        y,
  input  logic        z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic [15:0] capture_y,
  output logic [15:0] capture_z
);

`ifdef CALC_CHK_STOP_ON_ERR_EN
  localparam bit StopOnErr = 1'b1;
`else
  localparam bit StopOnErr = 1'b0;
`endif

  // Unused when SETTLE_CYCLES == 0 since APPLY then skips SETTLE entirely.
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [4:0]  err_q, err_d;
  logic [3:0]  first_q, first_d;
  logic [15:0] cap_y_q, cap_y_d;
  logic [15:0] cap_z_q, cap_z_d;
  logic        mismatch;

  assign mismatch = (y != EXPECTED_Y[idx_q]) || (z != EXPECTED_Z[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    cap_y_d = cap_y_q;
    cap_z_d = cap_z_q;
    // done is registered, so it rises one edge after DONE is entered and drops with start.
    done_d  = (state_q == StDone) && !start;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d   = '0;
          first_d = '0;
          cap_y_d = '0;
          cap_z_d = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          state_d = StApply;
        end
      end
      StApply: begin
        vec_d   = idx_q;
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? StSample : StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSample: begin
        cap_y_d[idx_q] = y;
        cap_z_d[idx_q] = z;
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (err_q == 5'd0) first_d = idx_q;
        end
        if ((StopOnErr && mismatch) || (idx_q == 4'hF)) begin
          state_d = StDone;
          pass_d  = (err_d == 5'd0);
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      cap_y_q <= '0;
      cap_z_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
      cap_y_q <= cap_y_d;
      cap_z_q <= cap_z_d;
    end
  end

  assign {a, b, c, d}  = vec_q;
  assign busy          = (state_q == StApply) || (state_q == StSettle) || (state_q == StSample);
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign capture_y     = cap_y_q;
  assign capture_z     = cap_z_q;

endmodule

// File: tb/tb_calc_vector_checker.sv
// Directed bench: two checkers (settle 4 and settle 0) each driving a behavioural calculator
// whose y can be inverted and z forced low to create mismatches.
module tb_calc_vector_checker;

  logic clk = 1'b0;
  logic reset, start;
  logic inv_y, zero_z;

  logic a, b, c, d, y, z, busy, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic [15:0] capture_y, capture_z;

  logic a0, b0, c0, d0, y0, z0, busy0, done0, pass0;
  logic [4:0]  err_count0;
  logic [3:0]  first_err_idx0;
  logic [15:0] capture_y0, capture_z0;

  int errors = 0;
  int checks = 0;
  int n, n0;

  always #5 clk = ~clk;

  assign y  = (^{a, b, c, d}) ^ inv_y;
  assign z  = (&{a, b, c, d}) & ~zero_z;
  assign y0 = (^{a0, b0, c0, d0}) ^ inv_y;
  assign z0 = (&{a0, b0, c0, d0}) & ~zero_z;

  calc_vector_checker #(.SETTLE_CYCLES(4)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
    .c            (c),
    .d            (d),
    .y            (y),
    .z            (z),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .capture_y    (capture_y),
    .capture_z    (capture_z)
  );

  calc_vector_checker #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a            (a0),
    .b            (b0),
    .c            (c0),
    .d            (d0),
    .y            (y0),
    .z            (z0),
    .busy         (busy0),
    .done         (done0),
    .pass         (pass0),
    .err_count    (err_count0),
    .first_err_idx(first_err_idx0),
    .capture_y    (capture_y0),
    .capture_z    (capture_z0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge (edge 0 of the sweep).
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until each done rises; optional start pulses at edges pa/pb.
  task automatic wait_done(input int pa, input int pb, output int nd, output int nd0);
    nd  = 0;
    nd0 = 0;
    for (int k = 1; k <= 300; k++) begin
      start = (k == pa) || (k == pb);
      tick();
      if (done && nd == 0) nd = k;
      if (done0 && nd0 == 0) nd0 = k;
      if (nd != 0 && nd0 != 0) break;
    end
    start = 1'b0;
    chk("done_within_budget", {30'd0, nd != 0, nd0 != 0}, 32'd3);
  endtask

  task automatic chk_clean(input string tag);
    chk({tag, "_pass"},   pass,          1);
    chk({tag, "_err"},    err_count,     0);
    chk({tag, "_first"},  first_err_idx, 0);
    chk({tag, "_capy"},   capture_y,     32'h6996);
    chk({tag, "_capz"},   capture_z,     32'h8000);
    chk({tag, "_abcd"},   {a, b, c, d},  4'hF);
    chk({tag, "_busy"},   busy,          0);
    chk({tag, "_pass0"},  pass0,         1);
    chk({tag, "_err0"},   err_count0,    0);
    chk({tag, "_capy0"},  capture_y0,    32'h6996);
    chk({tag, "_capz0"},  capture_z0,    32'h8000);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    inv_y  = 1'b0;
    zero_z = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset with no start.
    repeat (50) tick();
    chk("idle_abcd",  {a, b, c, d}, 0);
    chk("idle_busy",  busy, 0);
    chk("idle_done",  done, 0);
    chk("idle_pass",  pass, 0);
    chk("idle_err",   err_count, 0);
    chk("idle_first", first_err_idx, 0);
    chk("idle_capy",  capture_y, 0);
    chk("idle_capz",  capture_z, 0);
    chk("idle_done0", done0, 0);

    // Clean sweep: done 97 edges (settle 4) / 33 edges (settle 0) after the start edge.
    go();
    chk("run_busy", busy, 1);
    chk("run_done", done, 0);
    wait_done(0, 0, n, n0);
    chk("t2_done_edge",  n,  97);
    chk("t2_done_edge0", n0, 33);
    chk_clean("t2");

    // z stuck low: only vector 15 mismatches.
    zero_z = 1'b1;
    go();
    chk("t3_done_cleared", done, 0);
    chk("t3_busy", busy, 1);
    wait_done(0, 0, n, n0);
    chk("t3_pass",  pass, 0);
    chk("t3_err",   err_count, 1);
    chk("t3_first", first_err_idx, 15);
    chk("t3_capz",  capture_z, 0);
    chk("t3_capy",  capture_y, 32'h6996);
    chk("t3_err0",  err_count0, 1);
    zero_z = 1'b0;

    // y inverted: every vector mismatches.
    inv_y = 1'b1;
    go();
    wait_done(0, 0, n, n0);
    chk("t4_pass",  pass, 0);
    chk("t4_first", first_err_idx, 0);
`ifdef CALC_CHK_STOP_ON_ERR_EN
    chk("t4_err",   err_count, 1);
    chk("t4_abcd",  {a, b, c, d}, 0);
    chk("t4_capy",  capture_y, 32'h0001);
    chk("t4_capz",  capture_z, 0);
    chk("t4_edge",  n, 7);
`else
    chk("t4_err",   err_count, 16);
    chk("t4_abcd",  {a, b, c, d}, 4'hF);
    chk("t4_capy",  capture_y, 32'h9669);
    chk("t4_capz",  capture_z, 32'h8000);
    chk("t4_err0",  err_count0, 16);
`endif
    inv_y = 1'b0;

    // Start pulses while busy must not restart or delay the sweep.
    go();
    wait_done(10, 20, n, n0);
    chk("t5_done_edge",  n,  97);
    chk("t5_done_edge0", n0, 33);
    chk_clean("t5");

    // Reset during vector 7 discards everything.
    go();
    repeat (45) tick();
    chk("t5_midsweep_busy", busy, 1);
    chk("t5_midsweep_abcd", {a, b, c, d}, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_abcd", {a, b, c, d}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err",  err_count, 0);
    chk("rst_first", first_err_idx, 0);
    chk("rst_capy", capture_y, 0);
    chk("rst_capz", capture_z, 0);
    chk("rst_done0", done0, 0);

    // Fresh sweep after the reset.
    go();
    wait_done(0, 0, n, n0);
    chk("t5b_done_edge",  n,  97);
    chk("t5b_done_edge0", n0, 33);
    chk_clean("t5b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
